dma_hostrd_burst_sequencer: RTL and testbench

//  Sequences host-to-FPGA (host-read) DMA transfers. Pops one command at a time from the host-rd command queue.

---
 rtl/dma_hostrd_burst_sequencer_pkg.sv | 30 +++
 rtl/dma_hostrd_burst_sequencer_burst_size_calc.sv | 27 ++
 rtl/dma_hostrd_burst_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_dma_hostrd_burst_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_hostrd_burst_sequencer_pkg.sv
// dma_hostrd_burst_sequencer_pkg
//   Shared constants and types for the host-read DMA burst sequencer.
//   Constants mirror the wider DMA package so the sequencer builds standalone.
//   Contents:
//     HOST_MEM_ADDR_WIDTH, DEVICE_MEM_ADDR_WIDTH, XFER_SIZE_WIDTH   address/length widths
//     HOST_MEM_RD_BURSTCOUNT_MAX                                     max words per read burst
//     RDDATA_BUFFER_DEPTH                                            read-data buffer depth, words
//     HOSTRD_SEQ_CREDIT_W                                            width of credit/outstanding math
//     hostrd_seq_state_t                                             sequencer FSM states

package dma_hostrd_burst_sequencer_pkg;

    localparam int unsigned HOST_MEM_ADDR_WIDTH        = 48;
    localparam int unsigned DEVICE_MEM_ADDR_WIDTH      = 34;
    localparam int unsigned XFER_SIZE_WIDTH            = 40;
    localparam int unsigned HOST_MEM_RD_BURSTCOUNT_MAX = 4;
    localparam int unsigned RDDATA_BUFFER_DEPTH        = 1024;

    // Enough bits to hold 0..RDDATA_BUFFER_DEPTH inclusive.
    localparam int unsigned HOSTRD_SEQ_CREDIT_W = $clog2(RDDATA_BUFFER_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        DONE
    } hostrd_seq_state_t;

endpackage

// File: rtl/dma_hostrd_burst_sequencer_burst_size_calc.sv
// dma_burst_size_calc
//   Combinational burst sizer: min(rem_words, BURST_MAX - word index within the
//   BURST_MAX-aligned block). With 64B words and BURST_MAX=4 this keeps every
//   burst inside one 256B block. Shared with the host-write sequencer.
//   Ports:
//     rem_words    in   REM_W  words still to request
//     word_idx     in   IDX_W  low bits of the word address (addr[6 +: IDX_W])
//     burst_count  out  7      words in the next burst (1..BURST_MAX when rem_words>0)

module dma_burst_size_calc #(
    parameter int unsigned REM_W     = 34,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned IDX_W     = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1
) (
    input  logic [REM_W-1:0] rem_words,
    input  logic [IDX_W-1:0] word_idx,
    output logic [6:0]       burst_count
);

    logic [REM_W-1:0] room;

    // Masking keeps the BURST_MAX=1 case correct (room is always 1).
    assign room = REM_W'(BURST_MAX) - (REM_W'(word_idx) & REM_W'(BURST_MAX - 1));

    assign burst_count = (rem_words < room) ? rem_words[6:0] : room[6:0];

endmodule

// File: rtl/dma_hostrd_burst_sequencer.sv
// dma_hostrd_burst_sequencer
//   Pops host-read DMA commands, splits each into AVMM read bursts that never
//   cross a BURST_MAX*64B boundary, throttles against read-buffer free space and
//   pulses xfer_done when all data of a command has returned.
//   Optional feature macro: DMA_HOSTRD_SEQ_PERF_CNT_EN enables perf_bursts /
//   perf_beats counters; otherwise both outputs are tied to 0.
//   Ports:
//     clk, reset, sclr            clock, sync active-high reset, soft clear (same effect)
//     cmd_valid/cmd_ready         command queue handshake (pop on valid & ready)
//     cmd_src_addr/dst_addr/length command fields
//     buf_free_words              free read-buffer entries
//     rd_read/address/burstcount  AVMM read request (registered, held under waitrequest)
//     rd_waitrequest              AVMM backpressure
//     rd_readdatavalid            AVMM read-data beat
//     xfer_dst_addr, xfer_words   latched command info
//     busy, xfer_done             status / completion pulse
//     err_unaligned               sticky unaligned-source error
//     perf_bursts, perf_beats     optional performance counters

module dma_hostrd_burst_sequencer
    import dma_hostrd_burst_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W    = HOST_MEM_ADDR_WIDTH,
    parameter int unsigned DST_W     = DEVICE_MEM_ADDR_WIDTH,
    parameter int unsigned LEN_W     = XFER_SIZE_WIDTH,
    parameter int unsigned BURST_MAX = HOST_MEM_RD_BURSTCOUNT_MAX,
    parameter int unsigned BUF_DEPTH = RDDATA_BUFFER_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_addr,
    input  logic [DST_W-1:0]  cmd_dst_addr,
    input  logic [LEN_W-1:0]  cmd_length,
    input  logic [10:0]       buf_free_words,
    output logic              rd_read,
    output logic [ADDR_W-1:0] rd_address,
    output logic [6:0]        rd_burstcount,
    input  logic              rd_waitrequest,
    input  logic              rd_readdatavalid,
    output logic [DST_W-1:0]  xfer_dst_addr,
    output logic [LEN_W-7:0]  xfer_words,
    output logic              busy,
    output logic              xfer_done,
    output logic              err_unaligned,
    output logic [63:0]       perf_bursts,
    output logic [63:0]       perf_beats
);

    localparam int unsigned REM_W = LEN_W - 6;
    localparam int unsigned IDX_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int unsigned CW    = HOSTRD_SEQ_CREDIT_W;

    hostrd_seq_state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;        // address of the next burst to request
    logic [REM_W-1:0]  rem_q, rem_d;          // words not yet requested
    logic [REM_W-1:0]  words_q, words_d;
    logic [DST_W-1:0]  dst_q, dst_d;
    logic [CW-1:0]     out_q, out_d;          // words requested but not yet returned
    logic              rd_read_q, rd_read_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [6:0]        rd_bc_q, rd_bc_d;
    logic              err_q, err_d;

    logic              pop;
    logic              accept;
    logic              beat_dec;
    logic [REM_W-1:0]  words_pop;
    logic [ADDR_W-1:0] addr_after;
    logic [REM_W-1:0]  rem_after;
    logic [6:0]        bc_next;
    logic signed [CW:0] credit;
    logic              credit_ok;

    assign cmd_ready = (state_q == IDLE) & ~reset & ~sclr;
    assign pop       = cmd_valid & cmd_ready;
    assign accept    = rd_read_q & ~rd_waitrequest;
    // Stray beats at zero outstanding are dropped so the count saturates at 0.
    assign beat_dec  = rd_readdatavalid & (out_q != '0);

    assign words_pop = cmd_length[LEN_W-1:6] + REM_W'(|cmd_length[5:0]);

    // Pointer/remaining as they will be after this cycle's accept, so the next
    // burst can be loaded on the same edge (back-to-back issue).
    assign addr_after = accept ? addr_q + (ADDR_W'(rd_bc_q) << 6) : addr_q;
    assign rem_after  = accept ? rem_q - REM_W'(rd_bc_q) : rem_q;

    dma_burst_size_calc #(
        .REM_W    (REM_W),
        .BURST_MAX(BURST_MAX),
        .IDX_W    (IDX_W)
    ) u_burst_size_calc (
        .rem_words  (rem_after),
        .word_idx   (addr_after[6 +: IDX_W]),
        .burst_count(bc_next)
    );

    // Credit uses the post-update outstanding count so a just-accepted burst
    // is already charged against the buffer.
    assign credit    = $signed({1'b0, buf_free_words}) - $signed({1'b0, out_d});
    assign credit_ok = credit >= $signed({{(CW - 6){1'b0}}, bc_next});

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        words_d   = words_q;
        dst_d     = dst_q;
        rd_read_d = rd_read_q;
        rd_addr_d = rd_addr_q;
        rd_bc_d   = rd_bc_q;
        err_d     = err_q;
        out_d     = out_q + (accept ? CW'(rd_bc_q) : '0) - CW'(beat_dec);

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    addr_d  = cmd_src_addr;
                    dst_d   = cmd_dst_addr;
                    words_d = words_pop;
                    rem_d   = words_pop;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (addr_q[5:0] != '0) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                addr_d = addr_after;
                rem_d  = rem_after;
                if (rem_after == '0) begin
                    rd_read_d = 1'b0;
                    state_d   = DRAIN;
                end else if (!rd_read_q || accept) begin
                    // Held requests (read & waitrequest) fall through untouched.
                    rd_read_d = credit_ok;
                    if (credit_ok) begin
                        rd_addr_d = addr_after;
                        rd_bc_d   = bc_next;
                    end
                end
            end
            DRAIN: begin
                if (out_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || sclr) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            words_q   <= '0;
            dst_q     <= '0;
            out_q     <= '0;
            rd_read_q <= 1'b0;
            rd_addr_q <= '0;
            rd_bc_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            words_q   <= words_d;
            dst_q     <= dst_d;
            out_q     <= out_d;
            rd_read_q <= rd_read_d;
            rd_addr_q <= rd_addr_d;
            rd_bc_q   <= rd_bc_d;
            err_q     <= err_d;
        end
    end

    assign rd_read       = rd_read_q;
    assign rd_address    = rd_addr_q;
    assign rd_burstcount = rd_bc_q;
    assign xfer_dst_addr = dst_q;
    assign xfer_words    = words_q;
    assign busy          = (state_q != IDLE);
    assign xfer_done     = (state_q == DONE);
    assign err_unaligned = err_q;

`ifdef DMA_HOSTRD_SEQ_PERF_CNT_EN
    logic [63:0] perf_bursts_q;
    logic [63:0] perf_beats_q;

    always_ff @(posedge clk) begin
        if (reset || sclr) begin
            perf_bursts_q <= '0;
            perf_beats_q  <= '0;
        end else begin
            if (accept) begin
                perf_bursts_q <= perf_bursts_q + 64'd1;
            end
            if (rd_readdatavalid) begin
                perf_beats_q <= perf_beats_q + 64'd1;
            end
        end
    end

    assign perf_bursts = perf_bursts_q;
    assign perf_beats  = perf_beats_q;
`else
    assign perf_bursts = '0;
    assign perf_beats  = '0;
`endif

endmodule

// File: tb/tb_dma_hostrd_burst_sequencer.sv
module tb_dma_hostrd_burst_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclr = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [47:0] cmd_src_addr = '0;
    logic [33:0] cmd_dst_addr = '0;
    logic [39:0] cmd_length = '0;
    logic [10:0] buf_free_words = 11'd1024;
    logic        rd_read;
    logic [47:0] rd_address;
    logic [6:0]  rd_burstcount;
    logic        rd_waitrequest = 1'b0;
    logic        rd_readdatavalid = 1'b0;
    logic [33:0] xfer_dst_addr;
    logic [33:0] xfer_words;
    logic        busy;
    logic        xfer_done;
    logic        err_unaligned;
    logic [63:0] perf_bursts;
    logic [63:0] perf_beats;

    always #5 clk = ~clk;

    dma_hostrd_burst_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .sclr            (sclr),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_src_addr    (cmd_src_addr),
        .cmd_dst_addr    (cmd_dst_addr),
        .cmd_length      (cmd_length),
        .buf_free_words  (buf_free_words),
        .rd_read         (rd_read),
        .rd_address      (rd_address),
        .rd_burstcount   (rd_burstcount),
        .rd_waitrequest  (rd_waitrequest),
        .rd_readdatavalid(rd_readdatavalid),
        .xfer_dst_addr   (xfer_dst_addr),
        .xfer_words      (xfer_words),
        .busy            (busy),
        .xfer_done       (xfer_done),
        .err_unaligned   (err_unaligned),
        .perf_bursts     (perf_bursts),
        .perf_beats      (perf_beats)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted-burst log and completion counter, sampled mid-cycle.
    logic [47:0] blog_addr[$];
    logic [6:0]  blog_bc[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rd_read && !rd_waitrequest) begin
            blog_addr.push_back(rd_address);
            blog_bc.push_back(rd_burstcount);
        end
        if (xfer_done) done_cnt++;
    end

    typedef struct {
        logic        sclr;
        logic        valid;
        logic [47:0] src;
        logic [39:0] len;
        logic [10:0] free;
        logic        rdv;
        logic        e_ready;
        logic        e_read;
        logic [47:0] e_addr;
        logic [6:0]  e_bc;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic v, input logic [47:0] src,
                                input logic [39:0] len, input logic [10:0] free, input logic rdv,
                                input logic er, input logic erd, input logic [47:0] ea,
                                input logic [6:0] eb, input logic ebz, input logic ed,
                                input logic ee);
        vec_t t;
        t.sclr = s; t.valid = v; t.src = src; t.len = len; t.free = free; t.rdv = rdv;
        t.e_ready = er; t.e_read = erd; t.e_addr = ea; t.e_bc = eb;
        t.e_busy = ebz; t.e_done = ed; t.e_err = ee;
        return t;
    endfunction

    vec_t tbl[26];

    // Issue one command, wait for exp_bursts accepted bursts, return all beats,
    // and require xfer_done exactly in the cycle after the last beat.
    task automatic do_xfer(input logic [47:0] src, input logic [39:0] len, input int exp_bursts);
        int n;
        int beats;
        int d0;
        blog_addr.delete();
        blog_bc.delete();
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_src_addr = src;
        cmd_dst_addr = 34'h2_0000_0040;
        cmd_length = len;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (blog_addr.size() < exp_bursts && n < 64) begin
            tick();
            n++;
        end
        check("burst_count_issued", blog_addr.size(), exp_bursts);
        check("xfer_dst_latched", xfer_dst_addr, 34'h2_0000_0040);
        beats = 0;
        foreach (blog_bc[k]) beats += int'(blog_bc[k]);
        for (int i = 0; i < beats; i++) begin
            rd_readdatavalid = 1'b1;
            tick();
        end
        rd_readdatavalid = 1'b0;
        check("done_after_last_beat", {xfer_done, done_cnt - d0}, {1'b1, 32'd0});
        tick();
        check("idle_after_done", {xfer_done, busy, cmd_ready}, 3'b001);
    endtask

    task automatic check_log(input string name, input int idx, input logic [47:0] a,
                             input logic [6:0] b);
        logic [54:0] g;
        g = (idx < blog_addr.size()) ? {blog_addr[idx], blog_bc[idx]} : '1;
        check(name, g, {a, b});
    endtask

    initial begin
        logic [59:0] got;
        logic [59:0] exp;
        logic [47:0] held_addr;
        int          n;
        int          d0;
        logic [63:0] exp_bursts;
        logic [63:0] exp_beats;

        // Cycle-by-cycle vectors: len=0, unaligned src, sclr clears error,
        // then credit throttling with a 512B command.
        tbl[0]  = mk(0, 1, 48'h2000,   0, 1024, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,          0, 1024, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0,          0, 1024, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[3]  = mk(0, 1, 48'h1004, 128, 1024, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0,          0, 1024, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0,          0, 1024, 0, 0, 0, 0, 0, 1, 1, 1);
        tbl[6]  = mk(1, 0, 0,          0, 1024, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0,          0, 1024, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 48'h3000, 512,    3, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0,          0,    3, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[10] = mk(0, 0, 0,          0,    3, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[11] = mk(0, 0, 0,          0,    3, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(0, 0, 0,          0,    4, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0,          0,    4, 0, 0, 1, 48'h3000, 4, 1, 0, 0);
        tbl[14] = mk(0, 0, 0,          0,    6, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[15] = mk(0, 0, 0,          0,    6, 1, 0, 0, 0, 0, 1, 0, 0);
        tbl[16] = mk(0, 0, 0,          0,    6, 1, 0, 0, 0, 0, 1, 0, 0);
        tbl[17] = mk(0, 0, 0,          0,    6, 0, 0, 1, 48'h3100, 4, 1, 0, 0);
        for (int i = 18; i < 24; i++) tbl[i] = mk(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0, 0);
        tbl[24] = mk(0, 0, 0,          0,    6, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[25] = mk(0, 0, 0,          0,    6, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset state
        tick(); tick();
        #2;
        check("reset_outputs",
              {cmd_ready, rd_read, busy, xfer_done, err_unaligned, rd_address, rd_burstcount,
               xfer_words, perf_bursts, perf_beats}, '0);
        tick();
        reset = 1'b0;
        tick();
        check("ready_after_reset", {cmd_ready, busy}, 2'b10);

        for (int i = 0; i < 26; i++) begin
            sclr = tbl[i].sclr;
            cmd_valid = tbl[i].valid;
            cmd_src_addr = tbl[i].src;
            cmd_length = tbl[i].len;
            buf_free_words = tbl[i].free;
            rd_readdatavalid = tbl[i].rdv;
            #3;
            got = {cmd_ready, rd_read, busy, xfer_done, err_unaligned,
                   tbl[i].e_read ? rd_address : 48'h0, tbl[i].e_read ? rd_burstcount : 7'h0};
            exp = {tbl[i].e_ready, tbl[i].e_read, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err,
                   tbl[i].e_addr, tbl[i].e_bc};
            check($sformatf("vec%0d", i), got, exp);
            tick();
        end
        sclr = 1'b0;
        cmd_valid = 1'b0;
        rd_readdatavalid = 1'b0;
        buf_free_words = 11'd1024;

        // 1 KB aligned: four bc=4 bursts back-to-back
        do_xfer(48'h1000, 40'd1024, 4);
        check_log("t1_b0", 0, 48'h1000, 7'd4);
        check_log("t1_b1", 1, 48'h1100, 7'd4);
        check_log("t1_b2", 2, 48'h1200, 7'd4);
        check_log("t1_b3", 3, 48'h1300, 7'd4);
        check("t1_xfer_words", xfer_words, 34'd16);

        // Start one word before a 256B boundary
        do_xfer(48'h10C0, 40'd320, 2);
        check_log("t2_b0", 0, 48'h10C0, 7'd1);
        check_log("t2_b1", 1, 48'h1100, 7'd4);

        // sclr while a request is stalled by waitrequest
        rd_waitrequest = 1'b1;
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_src_addr = 48'h4000;
        cmd_length = 40'd256;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rd_read && n < 16) begin
            tick();
            n++;
        end
        check("t5_read_up", rd_read, 1'b1);
        held_addr = rd_address;
        tick(); tick();
        check("t5_held", {rd_read, rd_address, rd_burstcount}, {1'b1, held_addr, 7'd4});
        check("t5_addr", held_addr, 48'h4000);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("t5_sclr_drop", {rd_read, busy}, 2'b00);
        rd_waitrequest = 1'b0;
        rd_readdatavalid = 1'b1;
        tick();
        rd_readdatavalid = 1'b0;
        check("t5_no_done_pulse", done_cnt - d0, 0);
        // Exactly 4 free words: issues only if the stray beat left outstanding at 0.
        buf_free_words = 11'd4;
        do_xfer(48'h5000, 40'd256, 1);
        check_log("t5_next_cmd", 0, 48'h5000, 7'd4);
        buf_free_words = 11'd1024;

        // Performance counters over two 1 KB transfers
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_xfer(48'h1000, 40'd1024, 4);
        do_xfer(48'h1000, 40'd1024, 4);
`ifdef DMA_HOSTRD_SEQ_PERF_CNT_EN
        exp_bursts = 64'd8;
        exp_beats  = 64'd32;
`else
        exp_bursts = 64'd0;
        exp_beats  = 64'd0;
`endif
        check("perf_bursts", perf_bursts, exp_bursts);
        check("perf_beats", perf_beats, exp_beats);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
